// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access unit.
// Size encodings, FSM state encoding and the default memory capacity.
package mem_access_pkg;

    localparam int MEM_BYTES_DEFAULT = 128;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_ST,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: extract/extend load lanes and merge store lanes.
// Purely combinational; the caller supplies the read word and the merge word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] ld_word_i,
    input  logic [31:0] st_word_i,
    input  logic [1:0]  offs_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_merge_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = ld_word_i[31:24];
        case (offs_i)
            2'd0: byte_lane = ld_word_i[31:24];
            2'd1: byte_lane = ld_word_i[23:16];
            2'd2: byte_lane = ld_word_i[15:8];
            2'd3: byte_lane = ld_word_i[7:0];
            default: byte_lane = ld_word_i[31:24];
        endcase
        half_lane = offs_i[1] ? ld_word_i[15:0] : ld_word_i[31:16];
    end

    always_comb begin
        ld_data_o = ld_word_i;
        case (size_i)
            SZ_BYTE: ld_data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: ld_data_o = {{16{signed_i & half_lane[15]}}, half_lane};
            default: ld_data_o = ld_word_i;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the old word survives.
    always_comb begin
        st_merge_o = st_word_i;
        case (size_i)
            SZ_BYTE: begin
                case (offs_i)
                    2'd0: st_merge_o[31:24] = wdata_i[7:0];
                    2'd1: st_merge_o[23:16] = wdata_i[7:0];
                    2'd2: st_merge_o[15:8]  = wdata_i[7:0];
                    2'd3: st_merge_o[7:0]   = wdata_i[7:0];
                    default: st_merge_o = st_word_i;
                endcase
            end
            SZ_HALF: begin
                if (offs_i[1]) st_merge_o[15:0]  = wdata_i[15:0];
                else           st_merge_o[31:16] = wdata_i[15:0];
            end
            default: st_merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit for a word-wide big-endian DataMemory.
// Sub-word stores use a read-modify-write pass through a merge register.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_RD,
    output logic        mem_WR,
    output logic [31:0] mem_DAddr,
    output logic [31:0] mem_DataIn,
    input  logic [31:0] mem_DataOut
);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] merge_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [32:0] end_addr_d;
    logic        misalign_d;
    logic        oob_d;
    logic        err_d;
    logic [31:0] ld_data;
    logic [31:0] st_merge;

    // 33-bit end address so a wrap near 2^32 still counts as out of range.
    always_comb begin
        end_addr_d = {1'b0, req_addr} + {30'b0, size_bytes(req_size)};
        oob_d      = end_addr_d > 33'(MEM_BYTES);
        misalign_d = ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        err_d      = (req_size == SZ_RSVD) || misalign_d || oob_d;
    end

    mem_lane_align u_align (
        .ld_word_i  (mem_DataOut),
        .st_word_i  (merge_q),
        .offs_i     (addr_q[1:0]),
        .size_i     (size_q),
        .signed_i   (signed_q),
        .wdata_i    (wdata_q),
        .ld_data_o  (ld_data),
        .st_merge_o (st_merge)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid) begin
                        addr_q       <= req_addr;
                        wdata_q      <= req_wdata;
                        size_q       <= req_size;
                        signed_q     <= req_signed;
                        resp_err_q   <= err_d;
                        resp_rdata_q <= '0;
                        if (err_d) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                        end else if (!req_write) begin
                            state_q <= S_LD;
                        end else if (req_size == SZ_WORD) begin
                            state_q <= S_ST;
                        end else begin
                            state_q <= S_RMW_RD;
                        end
                    end
                end
                S_LD: begin
                    resp_rdata_q <= ld_data;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_ST: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RMW_RD: begin
                    merge_q <= mem_DataOut;
                    state_q <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by Reset so a reset landing on a write cycle kills it.
    always_comb begin
        mem_RD = !Reset && ((state_q == S_LD) || (state_q == S_RMW_RD));
        mem_WR = !Reset && ((state_q == S_ST) || (state_q == S_RMW_WR));
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_DAddr  = {addr_q[31:2], 2'b00};
    assign mem_DataIn = st_merge;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a 128-byte big-endian memory model.
// Expected responses are queued on accept and checked when resp_valid fires.
module tb_mem_access_unit;

    logic        CLK;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_RD;
    logic        mem_WR;
    logic [31:0] mem_DAddr;
    logic [31:0] mem_DataIn;
    logic [31:0] mem_DataOut;

    mem_access_unit #(.MEM_BYTES(128)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_RD      (mem_RD),
        .mem_WR      (mem_WR),
        .mem_DAddr   (mem_DAddr),
        .mem_DataIn  (mem_DataIn),
        .mem_DataOut (mem_DataOut)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } sb_t;

    sb_t         sbq[$];
    logic [7:0]  mem[0:127];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    int          resp_cnt = 0;
    int          acc_cnt = 0;
    int          spur_cnt = 0;
    int          last_rd = 0;
    int          last_wr = 0;
    int          last_resp = 0;
    int          last_acc = 0;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [6:0]  da;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    assign da = mem_DAddr[6:0];
    always_comb begin
        if (mem_DAddr < 32'd128)
            mem_DataOut = {mem[da], mem[da + 7'd1], mem[da + 7'd2], mem[da + 7'd3]};
        else
            mem_DataOut = 32'h0;
    end

    function automatic logic [31:0] rdw(input int a);
        return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
    endfunction

    task automatic poke(input int a, input logic [31:0] w);
        mem[a]     = w[31:24];
        mem[a + 1] = w[23:16];
        mem[a + 2] = w[15:8];
        mem[a + 3] = w[7:0];
    endtask

    always @(negedge CLK) begin
        sb_t e;
        if (mem_RD && mem_WR) both_cnt++;
        if (mem_RD) begin
            rd_cnt++;
            last_rd = cyc;
        end
        if (mem_WR) begin
            wr_cnt++;
            last_wr = cyc;
            if (mem_DAddr < 32'd128) begin
                mem[da]         = mem_DataIn[31:24];
                mem[da + 7'd1]  = mem_DataIn[23:16];
                mem[da + 7'd2]  = mem_DataIn[15:8];
                mem[da + 7'd3]  = mem_DataIn[7:0];
            end
        end
        if (resp_valid) begin
            resp_cnt++;
            last_resp = cyc;
            if (sbq.size() == 0) begin
                spur_cnt++;
            end else begin
                e = sbq.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                chk("latency", cyc - e.acc, e.lat);
            end
        end
        if (req_valid && req_ready && !Reset) begin
            acc_cnt++;
            last_acc = cyc;
            e.err   = exp_err;
            e.rdata = exp_rdata;
            e.lat   = exp_lat;
            e.acc   = cyc;
            sbq.push_back(e);
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            #1;
            if (sbq.size() == 0) break;
        end
        chk("sb_drain", sbq.size(), 0);
        if (sbq.size() != 0) sbq.delete();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic e, input logic [31:0] rd, input int lat);
        exp_err    = e;
        exp_rdata  = rd;
        exp_lat    = lat;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic e, input logic [31:0] rd, input int lat);
        int n;
        set_req(w, sz, sg, a, wd, e, rd, lat);
        req_valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic err_case(input logic w, input logic [1:0] sz,
                            input logic [31:0] a);
        int r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        issue(w, sz, 1'b0, a, 32'hDEADBEEF, 1'b1, 32'h0, 1);
        chk("err_no_rd", rd_cnt - r0, 0);
        chk("err_no_wr", wr_cnt - w0, 0);
    endtask

    initial begin
        int a0, r0, w0, rr0, fr;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        Reset = 1'b1;
        req_valid = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0);
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b0;
        @(negedge CLK);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        @(posedge CLK);
        #1;

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 1'b0, 32'h0, 2);
        chk("sw_b0", {24'b0, mem[16]}, 32'h12);
        chk("sw_b1", {24'b0, mem[17]}, 32'h34);
        chk("sw_b2", {24'b0, mem[18]}, 32'h56);
        chk("sw_b3", {24'b0, mem[19]}, 32'h78);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12345678, 2);

        poke(32'h20, 32'hAABBCCDD);
        r0 = rd_cnt;
        w0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h22, 32'h00000011, 1'b0, 32'h0, 3);
        chk("sb_word", rdw(32'h20), 32'hAABB11DD);
        chk("sb_rd_once", rd_cnt - r0, 1);
        chk("sb_wr_once", wr_cnt - w0, 1);
        chk("rmw_seq", last_wr - last_rd, 1);

        poke(32'h30, 32'h80FF0000);
        issue(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 1'b0, 32'hFFFFFF80, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 1'b0, 32'h00000080, 2);
        issue(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0, 32'hFFFF80FF, 2);
        issue(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0, 32'h00000000, 2);
        issue(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 1'b0, 32'hFFFFFFFF, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 1'b0, 32'h000000FF, 2);
        issue(1'b1, 2'b01, 1'b0, 32'h32, 32'h1234BEEF, 1'b0, 32'h0, 3);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h80FFBEEF, 2);
        issue(1'b1, 2'b01, 1'b0, 32'h30, 32'h0000A5C3, 1'b0, 32'h0, 3);
        issue(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0000A5C3, 2);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'hA5C3BEEF, 2);

        poke(32'h7C, 32'hCAFEF00D);
        issue(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 1'b0, 32'hCAFEF00D, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h7F, 32'h0, 1'b0, 32'h0000000D, 2);

        err_case(1'b0, 2'b10, 32'h22);
        err_case(1'b0, 2'b01, 32'h21);
        err_case(1'b1, 2'b10, 32'h7E);
        err_case(1'b0, 2'b11, 32'h10);
        err_case(1'b1, 2'b11, 32'h10);
        err_case(1'b0, 2'b00, 32'h80);
        err_case(1'b0, 2'b01, 32'h7F);
        err_case(1'b1, 2'b01, 32'hFFFFFFFE);

        // reset lands on the RMW_WR cycle of a byte store
        poke(32'h40, 32'h01020304);
        r0 = rd_cnt;
        w0 = wr_cnt;
        rr0 = resp_cnt;
        set_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h00000055, 1'b0, 32'h0, 3);
        req_valid = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        sbq.delete();
        @(negedge CLK);
        chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge CLK);
        chk("rstmid_rd", rd_cnt - r0, 1);
        chk("rstmid_wr", wr_cnt - w0, 0);
        chk("rstmid_resp", resp_cnt - rr0, 0);
        chk("rstmid_mem", rdw(32'h40), 32'h01020304);
        @(posedge CLK);
        #1;

        // req_valid held through a load: one response per accept
        a0 = acc_cnt;
        rr0 = resp_cnt;
        fr = -1;
        set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12345678, 2);
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            if (fr < 0 && resp_cnt == rr0 + 1) fr = last_resp;
            if (acc_cnt >= a0 + 2) break;
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        wait_drain();
        chk("b2b_accepts", acc_cnt - a0, 2);
        chk("b2b_resps", resp_cnt - rr0, 2);
        chk("b2b_gap", last_acc - fr, 1);

        repeat (3) @(posedge CLK);
        chk("rd_wr_excl", both_cnt, 0);
        chk("spurious_resp", spur_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
